bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
//  Generalises the fixed 6-bit 2-digit combinational LUT: width and digit count are parameters.
//  Adds valid/ready handshakes on both sides, overflow detection and optional saturation.
//  Sits between ATM balance/amount registers and the 7-segment display drivers.
// PARAMETERS
//  BIN_W     16  binary input width, 2..32
//  DIGITS     5  BCD digits produced, 1..10; need not cover full range (see ovf)
//  SATURATE   0  1: on overflow drive all digits to 9; 0: output truncated low digits
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          bin is valid
//  in_ready   out  1          converter idle, accepts bin
//  bin        in   BIN_W      unsigned binary value
//  out_valid  out  1          bcd/ovf valid, held until accepted
//  out_ready  in   1          consumer accepts result
//  bcd        out  4*DIGITS   digit k at [4k+3:4k], digit 0 = least significant
//  ovf        out  1          value exceeds 10^DIGITS-1
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, bcd=0, ovf=0, counter=0.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready edge: capture bin into shift reg, clear BCD accumulator
//   and sticky ovf, counter=BIN_W, go to SHIFT.
//  SHIFT: each edge: every digit >=5 gets +3, then {acc,shift} shifts left 1; if acc MSB is 1
//   before the shift, set sticky ovf. Counter decrements; after BIN_W shift edges go to DONE.
//  DONE: out_valid=1; bcd/ovf stable. out_valid&&out_ready edge -> IDLE, out_valid=0.
//  Latency: out_valid rises on the BIN_W-th edge after the accepting edge; throughput 1 per BIN_W+2 clocks.
//  in_ready=0 in SHIFT and DONE; in_valid there is ignored (no capture, no queue).
//  bin is sampled only on the accepting edge; later changes have no effect.
//  bcd/ovf registered; change only on the DONE-entry edge and reset; in IDLE/SHIFT they hold the last result.
//  SATURATE=1 and ovf=1: bcd = all 4'h9. SATURATE=0: bcd = low DIGITS digits of true value.
//  Every digit of bcd is always 0..9 (never A..F).
//  bin=0 -> bcd=0, ovf=0, same latency (no early exit).
//  Reset mid-SHIFT or mid-DONE: result discarded, outputs return to reset values immediately.
// STRUCTURE
//  Shared package bcd_pkg: state enum (ST_IDLE, ST_SHIFT, ST_DONE), localparam BCD_NINE=4'h9,
//   function clog2 for counter width ($clog2(BIN_W+1)).
//  Sub-module bcd_digit_adj: 4-bit combinational add-3-if->=5, one instance per digit via generate.
//  Top: FSM, counter, shift/accumulator register, sticky ovf, saturation mux on output register.
// TESTING
//  BIN_W=16,DIGITS=5: bin=16'd60 -> out_valid after 16 clocks, bcd=20'h00060, ovf=0.
//  BIN_W=16,DIGITS=5: bin=16'hFFFF -> bcd=20'h65535, ovf=0; bin=0 -> bcd=0, same latency.
//  BIN_W=8,DIGITS=2,SATURATE=0: bin=255 -> bcd=8'h55, ovf=1; SATURATE=1 -> bcd=8'h99, ovf=1; bin=99 -> 8'h99, ovf=0.
//  Backpressure: out_ready low 10 clocks in DONE -> out_valid/bcd held, in_ready=0, new in_valid ignored.
//  Back-to-back: 37 then 1234 with out_ready=1 -> results 00037, 01234 in order, in_ready high between.
//  rst_n low at shift 7 of 16 -> out_valid=0,bcd=0 at once; next conversion of 999 -> 00999 correct.
//  Exhaustive BIN_W=6,DIGITS=2: all 64 values vs reference tens/ones model, ovf=0 for 0..63.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the saturation digit and a counter-width helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'h9;

   // Smallest r with 2**r >= value; used as clog2(BIN_W+1) for the shift counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between a binary producer, the BCD converter and the display consumer.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   // Both sides use valid/ready: a transfer happens on a rising clk edge where valid and
   // ready are both high; valid, once raised, holds its payload stable until that edge.
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd, ovf
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd, ovf
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of shift-and-add-3: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3),
// with valid/ready on both sides, sticky overflow and optional saturation to all nines.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W    = 16,
   parameter int DIGITS   = 5,
   parameter int SATURATE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   bin_to_bcd_seq_if.slave bus,
   output state_t       dbg_state
);

   localparam int CNT_W = clog2(BIN_W + 1);
   localparam int ACC_W = 4 * DIGITS;
   localparam logic [ACC_W-1:0] NINES = {DIGITS{BCD_NINE}};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]   sh_q, sh_nxt;
   logic [ACC_W-1:0]   acc_q, acc_adj, acc_nxt;
   logic               ovf_sticky_q, ovf_nxt;
   logic [ACC_W-1:0]   bcd_q, result;
   logic               ovf_q;
   logic               accept, last_shift;

   assign accept     = (state_q == ST_IDLE) && bus.in_valid;
   assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
         );
      end
   endgenerate

   // A set MSB in the corrected top digit would be shifted out: that lost bit is worth
   // 10^DIGITS, so the low digits stay exact (value mod 10^DIGITS) while ovf latches.
   assign {acc_nxt, sh_nxt} = {acc_adj, sh_q} << 1;
   assign ovf_nxt           = ovf_sticky_q | acc_adj[ACC_W-1];
   assign result            = ((SATURATE != 0) && ovf_nxt) ? NINES : acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.in_valid)  state_d = ST_SHIFT;
         ST_SHIFT: if (last_shift)    state_d = ST_DONE;
         ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         sh_q         <= '0;
         acc_q        <= '0;
         ovf_sticky_q <= 1'b0;
         bcd_q        <= '0;
         ovf_q        <= 1'b0;
      end else begin
         if (accept) begin
            sh_q         <= bus.bin;
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
            cnt_q        <= CNT_W'(BIN_W);
         end else if (state_q == ST_SHIFT) begin
            sh_q         <= sh_nxt;
            acc_q        <= acc_nxt;
            ovf_sticky_q <= ovf_nxt;
            cnt_q        <= cnt_q - CNT_W'(1);
            // Outputs only move on the edge that enters DONE.
            if (last_shift) begin
               bcd_q <= result;
               ovf_q <= ovf_nxt;
            end
         end
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.bcd       = bcd_q;
   assign bus.ovf       = ovf_q;
   assign dbg_state     = state_q;

endmodule
